// File: rtl/bs_display_arbiter_if.sv
// Board-side bundle for bs_display_arbiter: per-player modes, board data and win flags in,
// LED/seven-segment/anode pins and status out.
interface bs_display_arbiter_if;
    logic [2:0]  disp_a;
    logic [2:0]  disp_b;
    logic [15:0] board_a;
    logic [15:0] board_b;
    logic [3:0]  hits_a;
    logic [3:0]  hits_b;
    logic        win_a;
    logic        win_b;
    logic [15:0] led;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [1:0]  owner;
    logic        err_busy;

    modport master (
        output disp_a, disp_b, board_a, board_b, hits_a, hits_b, win_a, win_b,
        input  led, seg, an, owner, err_busy
    );

    modport slave (
        input  disp_a, disp_b, board_a, board_b, hits_a, hits_b, win_a, win_b,
        output led, seg, an, owner, err_busy
    );
endinterface

// File: rtl/bs_display_arbiter.sv
// Shares the 4-digit seven-segment display and 16 LEDs between players A and B, with hand-off
// blanking, timed error hold and win screen. Define BS_ERR_BLINK_EN to blink the error screen.
module bs_display_arbiter #(
    parameter int REFRESH_DIV = 100000,
    parameter int ERR_HOLD    = 50000000,
    parameter int BLANK_CYC   = 25000000
) (
    input  logic                 clk,
    input  logic                 clr,
    bs_display_arbiter_if.slave  bus
);
    localparam int SCAN_W  = $clog2(REFRESH_DIV);
    localparam int ERR_W   = $clog2(ERR_HOLD);
    localparam int BLANK_W = $clog2(BLANK_CYC);

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(REFRESH_DIV - 1);
    localparam logic [ERR_W-1:0]   ERR_LAST   = ERR_W'(ERR_HOLD - 1);
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYC - 1);

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_A    = 2'b01;
    localparam logic [1:0] OWN_B    = 2'b10;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_U     = 7'h41;

    typedef enum logic [2:0] {S_IDLE, S_SHOW, S_BLANK, S_ERR, S_WIN} state_t;

    state_t             state_q;
    logic [1:0]         owner_q;
    logic [1:0]         target_q;
    logic [ERR_W-1:0]   errCnt_q;
    logic [BLANK_W-1:0] blankCnt_q;
    logic               errBusy_q;

    logic [SCAN_W-1:0]  scan_q;
    logic [1:0]         digit_q;
    logic [15:0]        led_q, led_d;
    logic [6:0]         seg_q, seg_d;
    logic [3:0]         an_q, an_d;

    logic aimA, aimB, errA, errB, bothIdle, anyWin, errLit;

    assign aimA     = (bus.disp_a == 3'd1);
    assign aimB     = (bus.disp_b == 3'd1);
    assign errA     = (bus.disp_a == 3'd5);
    assign errB     = (bus.disp_b == 3'd5);
    assign bothIdle = (bus.disp_a == 3'd0) && (bus.disp_b == 3'd0);
    assign anyWin   = bus.win_a | bus.win_b;

    function automatic logic [6:0] decSeg(input logic [3:0] d);
        case (d)
            4'd0:    decSeg = 7'h40;
            4'd1:    decSeg = 7'h79;
            4'd2:    decSeg = 7'h24;
            4'd3:    decSeg = 7'h30;
            4'd4:    decSeg = 7'h19;
            4'd5:    decSeg = 7'h12;
            4'd6:    decSeg = 7'h02;
            4'd7:    decSeg = 7'h78;
            4'd8:    decSeg = 7'h00;
            4'd9:    decSeg = 7'h10;
            default: decSeg = SEG_BLANK;
        endcase
    endfunction

    // Priority: win > error hold > error entry > blank countdown > hand-off > idle.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_NONE;
            target_q   <= OWN_NONE;
            errCnt_q   <= '0;
            blankCnt_q <= '0;
            errBusy_q  <= 1'b0;
        end else if (anyWin) begin
            if (state_q != S_WIN) begin
                state_q <= S_WIN;
                owner_q <= bus.win_a ? OWN_A : OWN_B;
            end
            errBusy_q <= 1'b0;
        end else if (state_q == S_ERR) begin
            if (errCnt_q == '0) begin
                state_q   <= S_SHOW;
                errBusy_q <= 1'b0;
            end else begin
                errCnt_q <= errCnt_q - 1'b1;
            end
        end else if (state_q != S_WIN) begin
            if (errA || errB) begin
                state_q   <= S_ERR;
                owner_q   <= errA ? OWN_A : OWN_B;
                errCnt_q  <= ERR_LAST;
                errBusy_q <= 1'b1;
            end else if (state_q == S_BLANK) begin
                if (blankCnt_q == '0) begin
                    state_q <= S_SHOW;
                    owner_q <= target_q;
                end else begin
                    blankCnt_q <= blankCnt_q - 1'b1;
                end
            end else if ((owner_q == OWN_NONE) && (aimA || aimB)) begin
                state_q <= S_SHOW;
                owner_q <= aimA ? OWN_A : OWN_B;
            end else if (((owner_q == OWN_A) && aimB) || ((owner_q == OWN_B) && aimA)) begin
                state_q    <= S_BLANK;
                target_q   <= (owner_q == OWN_A) ? OWN_B : OWN_A;
                blankCnt_q <= BLANK_LAST;
            end else if (bothIdle) begin
                state_q <= S_IDLE;
                owner_q <= OWN_NONE;
            end
        end
    end

`ifdef BS_ERR_BLINK_EN
    localparam int BLINK_Q = (ERR_HOLD / 4 > 1) ? ERR_HOLD / 4 : 1;
    localparam int BLINK_W = (BLINK_Q > 1) ? $clog2(BLINK_Q) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_Q - 1);

    logic [BLINK_W-1:0] blinkCnt_q;
    logic               blinkLit_q;

    // Phase is held at "lit, count 0" outside ERR so every hold starts lit.
    always_ff @(posedge clk) begin
        if (clr || (state_q != S_ERR)) begin
            blinkCnt_q <= '0;
            blinkLit_q <= 1'b1;
        end else if (blinkCnt_q == BLINK_LAST) begin
            blinkCnt_q <= '0;
            blinkLit_q <= ~blinkLit_q;
        end else begin
            blinkCnt_q <= blinkCnt_q + 1'b1;
        end
    end

    assign errLit = blinkLit_q;
`else
    assign errLit = 1'b1;
`endif

    logic [3:0]      hitsSel;
    logic [3:0]      onesVal;
    logic [6:0]      ownerGlyph;
    logic [3:0][6:0] glyphs;
    logic            dark;

    always_comb begin
        hitsSel    = (owner_q == OWN_B) ? bus.hits_b : bus.hits_a;
        onesVal    = (hitsSel >= 4'd10) ? (hitsSel - 4'd10) : hitsSel;
        ownerGlyph = (owner_q == OWN_B) ? SEG_B : SEG_A;
        led_d      = '0;
        glyphs     = {SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH};
        dark       = 1'b0;
        case (state_q)
            S_SHOW: begin
                led_d  = (owner_q == OWN_B) ? bus.board_b : bus.board_a;
                glyphs = {ownerGlyph, SEG_BLANK,
                          decSeg((hitsSel >= 4'd10) ? 4'd1 : 4'd0), decSeg(onesVal)};
            end
            S_BLANK: dark = 1'b1;
            S_ERR: begin
                led_d  = errLit ? 16'hFFFF : 16'h0000;
                dark   = ~errLit;
                glyphs = {SEG_E, SEG_R, SEG_R, ownerGlyph};
            end
            S_WIN: begin
                led_d  = 16'hFFFF;
                glyphs = {ownerGlyph, SEG_DASH, SEG_U, SEG_U};
            end
            default: ;
        endcase
        an_d  = dark ? 4'hF : ~(4'b0001 << digit_q);
        seg_d = dark ? SEG_BLANK : glyphs[digit_q];
    end

    // Pin registers lag the state by one cycle; the scan keeps running in every state.
    always_ff @(posedge clk) begin
        if (clr) begin
            scan_q  <= '0;
            digit_q <= 2'd0;
            led_q   <= '0;
            an_q    <= 4'hF;
            seg_q   <= SEG_BLANK;
        end else begin
            if (scan_q == SCAN_LAST) begin
                scan_q  <= '0;
                digit_q <= digit_q + 2'd1;
            end else begin
                scan_q <= scan_q + 1'b1;
            end
            led_q <= led_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign bus.led      = led_q;
    assign bus.seg      = seg_q;
    assign bus.an       = an_q;
    assign bus.owner    = owner_q;
    assign bus.err_busy = errBusy_q;
endmodule

// File: tb/tb_bs_display_arbiter.sv
// Scoreboard bench for bs_display_arbiter: a screen-level model predicts every cycle's pins,
// a monitor compares them against the DUT.
module tb_bs_display_arbiter;
    localparam int REFRESH_DIV = 4;
    localparam int ERR_HOLD    = 10;
    localparam int BLANK_CYC   = 6;

    logic clk = 1'b0;
    logic clr = 1'b1;

    bs_display_arbiter_if bus ();

    bs_display_arbiter #(
        .REFRESH_DIV(REFRESH_DIV),
        .ERR_HOLD   (ERR_HOLD),
        .BLANK_CYC  (BLANK_CYC)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  owner;
        logic        busy;
        logic [15:0] led;
        logic [6:0]  seg;
        logic [3:0]  an;
    } exp_t;

    typedef enum {M_IDLE, M_SHOW, M_BLANK, M_ERR, M_WIN} mode_t;

    exp_t  expQ[$];
    int    tests = 0;
    int    fails = 0;

    mode_t mMode   = M_IDLE;
    int    mOwner  = 0;
    int    mTarget = 0;
    int    mRemain = 0;
    int    mCycle  = 0;

    logic [15:0] boardA = '0, boardB = '0;
    logic [3:0]  hitsA = '0, hitsB = '0;

    function automatic logic [6:0] charSeg(input byte c);
        case (c)
            "0": charSeg = 7'h40;
            "1": charSeg = 7'h79;
            "2": charSeg = 7'h24;
            "3": charSeg = 7'h30;
            "4": charSeg = 7'h19;
            "5": charSeg = 7'h12;
            "6": charSeg = 7'h02;
            "7": charSeg = 7'h78;
            "8": charSeg = 7'h00;
            "9": charSeg = 7'h10;
            "A": charSeg = 7'h08;
            "b": charSeg = 7'h03;
            "E": charSeg = 7'h06;
            "r": charSeg = 7'h2F;
            "U": charSeg = 7'h41;
            "-": charSeg = 7'h3F;
            default: charSeg = 7'h7F;
        endcase
    endfunction

    // Predicts the pins after the coming edge from the screen shown this cycle and the rules.
    task automatic modelStep();
        exp_t  e;
        string txt;
        string who;
        bit    dark;
        bit    lit;
        int    idx;
        int    hits;
        bit    aA, aB, eA, eB;
        e = '0;
        if (clr) begin
            e.led = 16'h0; e.an = 4'hF; e.seg = 7'h7F; e.owner = 2'b00; e.busy = 1'b0;
            mMode = M_IDLE; mOwner = 0; mTarget = 0; mRemain = 0; mCycle = 0;
            expQ.push_back(e);
            return;
        end
        idx  = (mCycle / REFRESH_DIV) % 4;
        who  = (mOwner == 2) ? "b" : "A";
        hits = (mOwner == 2) ? int'(bus.hits_b) : int'(bus.hits_a);
        dark = 0;
        lit  = 1;
`ifdef BS_ERR_BLINK_EN
        if (mMode == M_ERR) lit = (((ERR_HOLD - mRemain) / (ERR_HOLD / 4)) % 2) == 0;
`endif
        case (mMode)
            M_IDLE:  begin txt = "----"; e.led = 16'h0; end
            M_SHOW:  begin
                txt   = $sformatf("%s %0d%0d", who, hits / 10, hits % 10);
                e.led = (mOwner == 2) ? bus.board_b : bus.board_a;
            end
            M_BLANK: begin txt = "    "; dark = 1; e.led = 16'h0; end
            M_ERR:   begin txt = {"Err", who}; e.led = lit ? 16'hFFFF : 16'h0; dark = !lit; end
            default: begin txt = {who, "-UU"}; e.led = 16'hFFFF; end
        endcase
        e.an  = dark ? 4'hF : ~(4'b0001 << idx);
        e.seg = dark ? 7'h7F : charSeg(txt[3 - idx]);

        aA = (bus.disp_a == 3'd1); aB = (bus.disp_b == 3'd1);
        eA = (bus.disp_a == 3'd5); eB = (bus.disp_b == 3'd5);
        if (bus.win_a || bus.win_b) begin
            if (mMode != M_WIN) begin mMode = M_WIN; mOwner = bus.win_a ? 1 : 2; end
        end else if (mMode == M_WIN) begin
            mMode = M_WIN;
        end else if (mMode == M_ERR) begin
            if (mRemain == 1) mMode = M_SHOW;
            else mRemain--;
        end else if (eA || eB) begin
            mMode = M_ERR; mOwner = eA ? 1 : 2; mRemain = ERR_HOLD;
        end else if (mMode == M_BLANK) begin
            if (mRemain == 1) begin mMode = M_SHOW; mOwner = mTarget; end
            else mRemain--;
        end else if (mOwner == 0 && (aA || aB)) begin
            mMode = M_SHOW; mOwner = aA ? 1 : 2;
        end else if ((mOwner == 1 && aB) || (mOwner == 2 && aA)) begin
            mMode = M_BLANK; mTarget = 3 - mOwner; mRemain = BLANK_CYC;
        end else if (bus.disp_a == 3'd0 && bus.disp_b == 3'd0) begin
            mMode = M_IDLE; mOwner = 0;
        end
        mCycle++;
        e.owner = 2'(mOwner);
        e.busy  = (mMode == M_ERR);
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic clrIn, input logic [2:0] da, input logic [2:0] db,
                                 input logic wa, input logic wb, input int n);
        repeat (n) begin
            @(negedge clk);
            clr         = clrIn;
            bus.disp_a  = da;
            bus.disp_b  = db;
            bus.win_a   = wa;
            bus.win_b   = wb;
            bus.board_a = boardA;
            bus.board_b = boardB;
            bus.hits_a  = hitsA;
            bus.hits_b  = hitsB;
            modelStep();
        end
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    function automatic logic [2:0] pickMode();
        case ($urandom_range(0, 9))
            0, 1:    pickMode = 3'd0;
            2, 3, 4: pickMode = 3'd1;
            5, 6:    pickMode = 3'd2;
            7:       pickMode = 3'd5;
            8:       pickMode = 3'd3;
            default: pickMode = 3'd7;
        endcase
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("owner",    16'(bus.owner),    16'(e.owner));
                checkOutput("err_busy", 16'(bus.err_busy), 16'(e.busy));
                checkOutput("led",      bus.led,           e.led);
                checkOutput("seg",      16'(bus.seg),      16'(e.seg));
                checkOutput("an",       16'(bus.an),       16'(e.an));
            end
        end
    end

    initial begin
        logic wa;
        bus.disp_a = 3'd0; bus.disp_b = 3'd0; bus.win_a = 1'b0; bus.win_b = 1'b0;
        bus.board_a = '0; bus.board_b = '0; bus.hits_a = '0; bus.hits_b = '0;

        applyStimulus(1, 0, 0, 0, 0, 2);
        applyStimulus(0, 0, 0, 0, 0, 20);

        boardA = 16'hA5A5; hitsA = 4'd12; boardB = 16'h3C3C; hitsB = 4'd7;
        applyStimulus(0, 1, 0, 0, 0, 8);
        applyStimulus(0, 2, 1, 0, 0, 12);

        applyStimulus(0, 2, 5, 0, 0, 1);
        for (int i = 0; i < 12; i++) applyStimulus(0, pickMode(), pickMode(), 0, 0, 1);

        applyStimulus(0, 0, 0, 0, 0, 2);
        applyStimulus(0, 5, 5, 0, 0, 1);
        applyStimulus(0, 2, 2, 0, 0, 4);
        applyStimulus(0, 2, 2, 0, 1, 3);
        applyStimulus(0, 1, 0, 0, 0, 5);

        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 3);
        applyStimulus(0, 2, 1, 0, 0, 3);
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 4);

        for (int s = 0; s < 300; s++) begin
            boardA = 16'($urandom); boardB = 16'($urandom);
            hitsA  = 4'($urandom_range(0, 15)); hitsB = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) begin
                wa = 1'($urandom_range(0, 1));
                applyStimulus(0, pickMode(), pickMode(), wa, !wa || 1'($urandom_range(0, 1)), 3);
                applyStimulus(1, 0, 0, 0, 0, 1);
            end else if ($urandom_range(0, 49) == 0) begin
                applyStimulus(1, pickMode(), pickMode(), 0, 0, 1);
            end else begin
                applyStimulus(0, pickMode(), pickMode(), 0, 0, $urandom_range(1, 12));
            end
        end

        @(posedge clk);
        #2;
        checkOutput("drain", 16'(expQ.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
